mem_port_arb: RTL and testbench

//   Round-robin arbiter sharing one port of a dual-port mem instance (registered read, 1-cycle latency)

---
 rtl/mem_port_arb.sv | 201 ++++++++++++++++++++
 tb/tb_mem_port_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// mem_port_arb
//   Round-robin arbiter that shares one port of a registered-read memory
//   among P_NREQ requesters. Each access runs ARB -> ISSUE -> RESP. Under
//   contention the next owner is captured in RESP, so the arbiter completes
//   one access every two cycles.
//
// Ports
//   iw_clk, iw_rst_n          clock; synchronous active-low reset
//   iw_req/iw_we              per-requester request and write flag
//   iw_addr/iw_wdata          packed per-requester address / write data
//   ow_gnt                    one-hot owner of the port (ISSUE and RESP)
//   ow_ack                    one-hot completion pulse (RESP)
//   ow_rdata                  read data alongside ow_ack, 0 for writes
//   ow_busy                   high whenever the arbiter is not in ARB
//   ow_mem_we/addr/wdata      memory port controls, non-zero only in ISSUE
//   iw_mem_rdata              memory read data, one cycle after the address

`ifndef SIZE_ADDR
`define SIZE_ADDR 8
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 16
`endif

module mem_port_arb #(
  parameter int P_NREQ   = 2,
  parameter int P_ADDR_W = `SIZE_ADDR,
  parameter int P_DATA_W = `SIZE_DATA
) (
  input  logic                       iw_clk,
  input  logic                       iw_rst_n,
  input  logic [P_NREQ-1:0]          iw_req,
  input  logic [P_NREQ-1:0]          iw_we,
  input  logic [P_NREQ*P_ADDR_W-1:0] iw_addr,
  input  logic [P_NREQ*P_DATA_W-1:0] iw_wdata,
  output logic [P_NREQ-1:0]          ow_gnt,
  output logic [P_NREQ-1:0]          ow_ack,
  output logic [P_DATA_W-1:0]        ow_rdata,
  output logic                       ow_busy,
  output logic                       ow_mem_we,
  output logic [P_ADDR_W-1:0]        ow_mem_addr,
  output logic [P_DATA_W-1:0]        ow_mem_wdata,
  input  logic [P_DATA_W-1:0]        iw_mem_rdata
);

  localparam int IDX_W = (P_NREQ > 1) ? $clog2(P_NREQ) : 1;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [IDX_W-1:0]      last_r;
  logic [IDX_W-1:0]      owner_r;
  logic                  cap_we_r;
  logic [IDX_W-1:0]      base_s;
  logic [P_NREQ-1:0]     elig_s;
  logic                  win_vld_s;
  logic [IDX_W-1:0]      win_idx_s;
  logic                  capture_s;
  logic [P_NREQ-1:0]     gnt_r;
  logic [P_NREQ-1:0]     ack_r;
  logic                  busy_r;
  logic                  mem_we_r;
  logic [P_ADDR_W-1:0]   mem_addr_r;
  logic [P_DATA_W-1:0]   mem_wdata_r;

  function automatic logic [P_NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = P_NREQ'(1) << idx;
  endfunction

  // Round-robin search. In RESP the search starts after the current owner and
  // masks it out, because its request is still high during its own ack cycle.
  always_comb begin
    int                cand_i;
    logic [IDX_W-1:0]  cand_s;
    cand_i    = 0;
    cand_s    = '0;
    win_vld_s = 1'b0;
    win_idx_s = '0;
    if (state_r == ST_RESP) begin
      base_s = owner_r;
      elig_s = iw_req & ~onehot(owner_r);
    end else begin
      base_s = last_r;
      elig_s = iw_req;
    end
    for (int k = 1; k <= P_NREQ; k++) begin
      cand_i = (int'(base_s) + k) % P_NREQ;
      cand_s = IDX_W'(cand_i);
      if (!win_vld_s && elig_s[cand_s]) begin
        win_vld_s = 1'b1;
        win_idx_s = cand_s;
      end else begin
        win_vld_s = win_vld_s;
      end
    end
  end

  // Next-state logic; capture happens from ARB or directly from RESP.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    case (state_r)
      ST_ARB: begin
        if (win_vld_s) begin
          state_nxt_s = ST_ISSUE;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      ST_ISSUE: begin
        state_nxt_s = ST_RESP;
      end
      ST_RESP: begin
        if (win_vld_s) begin
          state_nxt_s = ST_ISSUE;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      default: begin
        state_nxt_s = ST_ARB;
      end
    endcase
  end

  // State register and round-robin pointer.
  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      state_r <= ST_ARB;
      last_r  <= IDX_W'(P_NREQ - 1);
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_RESP) begin
        last_r <= owner_r;
      end
    end
  end

  // Capture of the winner's request; the memory controls are loaded at the
  // capture edge so they are valid for exactly the ISSUE cycle.
  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      owner_r     <= '0;
      cap_we_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else if (capture_s) begin
      owner_r     <= win_idx_s;
      cap_we_r    <= iw_we[win_idx_s];
      mem_we_r    <= iw_we[win_idx_s];
      mem_addr_r  <= iw_addr[int'(win_idx_s)*P_ADDR_W +: P_ADDR_W];
      mem_wdata_r <= iw_wdata[int'(win_idx_s)*P_DATA_W +: P_DATA_W];
    end else begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end
  end

  // Grant, acknowledge and busy flags.
  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      gnt_r  <= '0;
      ack_r  <= '0;
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_ARB);
      if (capture_s) begin
        gnt_r <= onehot(win_idx_s);
      end else if (state_r == ST_RESP) begin
        gnt_r <= '0;
      end else begin
        gnt_r <= gnt_r;
      end
      if (state_r == ST_ISSUE) begin
        ack_r <= onehot(owner_r);
      end else begin
        ack_r <= '0;
      end
    end
  end

  assign ow_gnt       = gnt_r;
  assign ow_ack       = ack_r;
  assign ow_busy      = busy_r;
  assign ow_mem_we    = mem_we_r;
  assign ow_mem_addr  = mem_addr_r;
  assign ow_mem_wdata = mem_wdata_r;
  // The memory only returns data during RESP, so read data is passed through
  // gated by the (registered) ack rather than registered a second time.
  assign ow_rdata     = ((|ack_r) && !cap_we_r) ? iw_mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arb.sv
module tb_mem_port_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  ack;
  logic [15:0] rdata;
  logic        busy;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_init;

  logic [15:0] mem [0:255];
  logic [15:0] exp_mem [0:255];

  typedef struct packed {
    logic [1:0]  ack;
    logic [15:0] data;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt   = 0;

  always #5 clk = ~clk;

  mem_port_arb #(.P_NREQ(2), .P_ADDR_W(8), .P_DATA_W(16)) dut (
    .iw_clk(clk), .iw_rst_n(rst_n), .iw_req(req), .iw_we(we),
    .iw_addr(addr), .iw_wdata(wdata), .ow_gnt(gnt), .ow_ack(ack),
    .ow_rdata(rdata), .ow_busy(busy), .ow_mem_we(mem_we),
    .ow_mem_addr(mem_addr), .ow_mem_wdata(mem_wdata), .iw_mem_rdata(mem_rdata)
  );

  function automatic logic [15:0] init_val(input int a);
    logic [7:0] a8;
    a8 = a[7:0];
    if (a == 16) init_val = 16'h00A5;
    else         init_val = {a8 ^ 8'hC3, a8};
  endfunction

  // Memory model: registered read, write-first.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem_we ? mem_wdata : mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every ack pops one expected entry.
  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (ack != 2'b00) begin
      check("ack_in_gnt", {30'd0, ack & ~gnt}, 32'd0);
      if (sb_q.size() == 0) begin
        check("sb_unexpected_ack", {30'd0, ack}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_ack", {30'd0, ack}, {30'd0, e.ack});
        check("sb_rdata", {16'd0, rdata}, {16'd0, e.data});
      end
    end
  end

  task automatic drive(input int idx, input logic w, input logic [7:0] a, input logic [15:0] d);
    req[idx]             = 1'b1;
    we[idx]              = w;
    addr[idx*8 +: 8]     = a;
    wdata[idx*16 +: 16]  = d;
  endtask

  task automatic do_access(input int idx, input logic w, input logic [7:0] a, input logic [15:0] d);
    exp_t e;
    bit   got;
    e.ack  = 2'b01 << idx;
    e.data = w ? 16'h0000 : exp_mem[a];
    sb_q.push_back(e);
    if (w) exp_mem[a] = d;
    drive(idx, w, a, d);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (ack != 2'b00) got = 1'b1;
    end
    check("acc_ack_seen", {31'd0, got}, 32'd1);
    req[idx] = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int base_we;
    int nack;
    int cyc;
    int cnt [2];
    exp_t e;

    rst_n = 1'b0; req = 2'b11; we = 2'b00; addr = '0; wdata = '0; mem_init = 1'b1;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);

    // Reset with both requests high.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_gnt", {30'd0, gnt}, 32'd0);
      check("rst_ack", {30'd0, ack}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
      check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
      check("rst_rdata", {16'd0, rdata}, 32'd0);
    end
    req = 2'b00; mem_init = 1'b0; rst_n = 1'b1;
    tick();

    // Single read of 0x10, with cycle-exact timing.
    e.ack = 2'b01; e.data = 16'h00A5; sb_q.push_back(e);
    drive(0, 1'b0, 8'h10, 16'h0000);
    check("rd_idle_busy", {31'd0, busy}, 32'd0);
    tick();
    check("rd_issue_addr", {24'd0, mem_addr}, 32'h10);
    check("rd_issue_gnt", {30'd0, gnt}, 32'h1);
    check("rd_issue_busy", {31'd0, busy}, 32'd1);
    check("rd_issue_noack", {30'd0, ack}, 32'd0);
    tick();
    check("rd_resp_ack", {30'd0, ack}, 32'h1);
    check("rd_resp_rdata", {16'd0, rdata}, 32'h00A5);
    check("rd_resp_mem_addr", {24'd0, mem_addr}, 32'd0);
    req = 2'b00;
    tick();
    check("rd_after_ack", {30'd0, ack}, 32'd0);
    check("rd_after_busy", {31'd0, busy}, 32'd0);
    check("rd_after_gnt", {30'd0, gnt}, 32'd0);

    // Contention from reset: grants alternate 0,1,0,1..., acks every 2 cycles.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      e.ack  = (k % 2 == 0) ? 2'b01 : 2'b10;
      e.data = exp_mem[((k % 2 == 0) ? 8'h40 : 8'h50) + 8'(k / 2)];
      sb_q.push_back(e);
    end
    cnt[0] = 0; cnt[1] = 0;
    drive(0, 1'b0, 8'h40, 16'h0);
    drive(1, 1'b0, 8'h50, 16'h0);
    nack = 0; cyc = 0;
    while (nack < 8 && cyc < 40) begin
      tick();
      cyc++;
      if (ack != 2'b00) begin
        check("ctn_cycle", cyc, 2 * (nack + 1));
        check("ctn_order", {30'd0, ack}, (nack % 2 == 0) ? 32'h1 : 32'h2);
        for (int i = 0; i < 2; i++) begin
          if (ack[i]) begin
            cnt[i]++;
            if (cnt[i] == 4) req[i] = 1'b0;
            else addr[i*8 +: 8] = ((i == 0) ? 8'h40 : 8'h50) + 8'(cnt[i]);
          end
        end
        nack++;
      end
    end
    check("ctn_acks", nack, 8);
    tick();
    check("ctn_idle", {31'd0, busy}, 32'd0);

    // Write 0x20 from requester 1, then read it back from requester 0.
    base_we = we_cnt;
    do_access(1, 1'b1, 8'h20, 16'h1234);
    check("wr_we_cycles", we_cnt - base_we, 1);
    do_access(0, 1'b0, 8'h20, 16'h0000);

    // Reset sampled on the would-be capture edge: nothing issued, mem unchanged.
    base_we = we_cnt;
    drive(1, 1'b1, 8'h30, 16'hDEAD);
    rst_n = 1'b0;
    tick();
    check("rstcap_busy", {31'd0, busy}, 32'd0);
    check("rstcap_mem_we", {31'd0, mem_we}, 32'd0);
    req = 2'b00; rst_n = 1'b1;
    tick();
    check("rstcap_no_write", we_cnt - base_we, 0);
    do_access(0, 1'b0, 8'h30, 16'h0000);

    // Reset during ISSUE of a write: no ack, everything back to idle.
    drive(1, 1'b1, 8'h30, 16'hBEEF);
    tick();
    check("rstiss_busy", {31'd0, busy}, 32'd1);
    check("rstiss_mem_we", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("rstiss_ack", {30'd0, ack}, 32'd0);
    check("rstiss_gnt", {30'd0, gnt}, 32'd0);
    check("rstiss_busy0", {31'd0, busy}, 32'd0);
    req = 2'b00; rst_n = 1'b1;
    tick();
    check("rstiss_ack_late", {30'd0, ack}, 32'd0);
    exp_mem[8'h30] = 16'hBEEF;

    // Early drop: request removed during ISSUE, ack still pulses once.
    e.ack = 2'b01; e.data = exp_mem[8'h11]; sb_q.push_back(e);
    drive(0, 1'b0, 8'h11, 16'h0);
    tick();
    check("drop_issue_gnt", {30'd0, gnt}, 32'h1);
    req = 2'b00;
    tick();
    check("drop_ack", {30'd0, ack}, 32'h1);
    check("drop_rdata", {16'd0, rdata}, {16'd0, exp_mem[8'h11]});
    tick();
    check("drop_ack_once", {30'd0, ack}, 32'd0);
    check("drop_busy", {31'd0, busy}, 32'd0);

    tick();
    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
